// File: rtl/imem_pkg.sv
// Shared constants, output-state encoding and the power-up program image for imem_sync_loadable.
package imem_pkg;

  localparam int unsigned IMAGE_W = 32;
  localparam logic [IMAGE_W-1:0] NOP_WORD = 32'hE1A00000;

  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_RANGE    = 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_VALID,
    ST_HOLD
  } out_state_e;

  // Boot program; every word past the listed ones is a NOP.
  function automatic logic [IMAGE_W-1:0] default_image(input int unsigned idx);
    case (idx)
      0:       return 32'hE3A00001;
      1:       return 32'hE3A01002;
      2:       return 32'hE0802001;
      3:       return 32'hE2522001;
      4:       return 32'hE1A03002;
      5:       return 32'hEAFFFFFE;
      default: return NOP_WORD;
    endcase
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read port with read enable.
// IMEM_PARITY_EN adds an even-parity bit per word, checked on the read side.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic logic [DEPTH-1:0][WORD_W-1:0] power_up_image();
    logic [DEPTH-1:0][WORD_W-1:0] img;
    for (int unsigned i = 0; i < DEPTH; i++)
      img[i] = encode(DATA_W'(default_image(i)));
    return img;
  endfunction

  // Contents are not touched by reset; only the declaration sets the boot image.
  logic [DEPTH-1:0][WORD_W-1:0] mem = power_up_image();
  logic [WORD_W-1:0]            rword;

  always_ff @(posedge clk) begin
    if (rst_n && we)
      mem[waddr] <= encode(wdata);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rword <= encode(DATA_W'(NOP_WORD));
    else if (re)
      rword <= mem[raddr];
  end

  assign rdata = rword[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  assign parity_err = ^rword;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/imem_sync_loadable.sv
// Loadable instruction memory with registered read, fetch handshake, stall hold and fault flags.
// Optional word parity is enabled with the IMEM_PARITY_EN macro.
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic [1:0]        fault,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  out_state_e        state, state_next;
  logic              load_en_q, turnaround, accept;
  logic              fetch_in_range, load_in_range;
  logic              misalign_q, oor_q, parity_err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-3:0] fetch_idx, load_idx;

  assign fetch_idx      = fetch_addr[ADDR_W-1:2];
  assign load_idx       = load_addr[ADDR_W-1:2];
  assign fetch_in_range = fetch_idx < (ADDR_W-2)'(DEPTH);
  assign load_in_range  = load_idx < (ADDR_W-2)'(DEPTH);

  assign turnaround  = load_en_q && !load_en;
  assign busy        = load_en || turnaround;
  assign fetch_ready = !busy && !(rd_valid && stall);
  assign accept      = fetch_req && fetch_ready;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (load_en && load_we && load_in_range),
    .waddr      (load_idx[IDX_W-1:0]),
    .wdata      (load_data),
    .re         (accept),
    .raddr      (fetch_idx[IDX_W-1:0]),
    .rdata      (rdata),
    .parity_err (parity_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      load_en_q  <= 1'b0;
      misalign_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state     <= state_next;
      load_en_q <= load_en;
      if (accept) begin
        misalign_q <= fetch_addr[1:0] != 2'b00;
        oor_q      <= !fetch_in_range;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: if (accept) state_next = ST_VALID;
      ST_VALID: begin
        if (accept)     state_next = ST_VALID;
        else if (stall) state_next = ST_HOLD;
        else            state_next = ST_EMPTY;
      end
      ST_HOLD:  if (!stall) state_next = accept ? ST_VALID : ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // rd/fault come from registers that only move on an accepted fetch, so HOLD and EMPTY keep them.
  always_comb begin
    rd_valid              = state != ST_EMPTY;
    rd                    = (oor_q || parity_err) ? DATA_W'(NOP_WORD) : rdata;
    fault                 = '0;
    fault[FAULT_MISALIGN] = misalign_q;
    fault[FAULT_RANGE]    = oor_q || parity_err;
  end

endmodule
